// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_pkg
// Description : Standard progressive video mode timings and axis helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

    typedef struct packed {
        int visible;
        int front;
        int sync;
        int back;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } video_mode_t;

    localparam video_mode_t MODE_640X480_60 = '{
        h: '{visible: 640,  front: 16, sync: 96,  back: 48},
        v: '{visible: 480,  front: 10, sync: 2,   back: 33}
    };

    localparam video_mode_t MODE_800X600_60 = '{
        h: '{visible: 800,  front: 40, sync: 128, back: 88},
        v: '{visible: 600,  front: 1,  sync: 4,   back: 23}
    };

    localparam video_mode_t MODE_1024X768_60 = '{
        h: '{visible: 1024, front: 24, sync: 136, back: 160},
        v: '{visible: 768,  front: 3,  sync: 6,   back: 29}
    };

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : axis_counter
// Description : One raster axis: position counter with registered sync/blank.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_counter
    import video_timing_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = 1'b0,
    parameter int CW      = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          restart,
    output logic [CW-1:0] count,
    output logic          sync,
    output logic          blank,
    output logic          blank_next,
    output logic          wrap
);

    localparam int            c_total      = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] c_last       = CW'(c_total - 1);
    localparam logic [CW-1:0] c_visible    = CW'(VISIBLE);
    localparam logic [CW-1:0] c_sync_start = CW'(VISIBLE + FRONT);
    localparam logic [CW-1:0] c_sync_end   = CW'(VISIBLE + FRONT + SYNC);
    localparam logic [CW-1:0] c_one        = CW'(1);

    logic [CW-1:0] count_d, count_q;
    logic          sync_d, sync_q;
    logic          blank_d, blank_q;

    // Flags are decoded from the next count so they line up with it after the edge.
    always_comb begin
        wrap    = advance && (count_q == c_last);
        count_d = count_q;
        if (restart || wrap) begin
            count_d = '0;
        end else if (advance) begin
            count_d = count_q + c_one;
        end
        sync_d  = ((count_d >= c_sync_start) && (count_d < c_sync_end)) ? POL : ~POL;
        blank_d = (count_d >= c_visible);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sync_q  <= ~POL;
            blank_q <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            blank_q <= blank_d;
        end
    end

    assign count      = count_q;
    assign sync       = sync_q;
    assign blank      = blank_q;
    assign blank_next = blank_d;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Combined H/V raster timing generator with pixel-rate enable.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE  = MODE_640X480_60.h.visible,
    parameter int H_FRONT    = MODE_640X480_60.h.front,
    parameter int H_SYNC     = MODE_640X480_60.h.sync,
    parameter int H_BACK     = MODE_640X480_60.h.back,
    parameter int V_VISIBLE  = MODE_640X480_60.v.visible,
    parameter int V_FRONT    = MODE_640X480_60.v.front,
    parameter int V_SYNC     = MODE_640X480_60.v.sync,
    parameter int V_BACK     = MODE_640X480_60.v.back,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          restart,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    logic h_wrap, v_wrap;
    logic h_blank_next, v_blank_next;
    logic de_d, de_q;
    logic line_start_d, line_start_q;
    logic frame_start_d, frame_start_q;

    axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_SYNC_POL),
        .CW      (CW)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .advance    (clk_en),
        .restart    (restart),
        .count      (h_count),
        .sync       (hsync),
        .blank      (hblank),
        .blank_next (h_blank_next),
        .wrap       (h_wrap)
    );

    // The vertical axis steps once per horizontal wrap.
    axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (V_SYNC_POL),
        .CW      (CW)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .advance    (h_wrap),
        .restart    (restart),
        .count      (v_count),
        .sync       (vsync),
        .blank      (vblank),
        .blank_next (v_blank_next),
        .wrap       (v_wrap)
    );

    // A restart landing on a natural wrap collapses into the same single pulse.
    always_comb begin
        de_d          = ~h_blank_next & ~v_blank_next;
        line_start_d  = restart | h_wrap;
        frame_start_d = restart | (h_wrap & v_wrap);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen across three modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;
    import video_timing_pkg::*;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit hp, vp;
        int h, v;
        bit ls, fs;
    } mdl_t;

    typedef struct {
        logic en; logic rs;
        int h; int v;
        logic hs; logic vs; logic de; logic ls; logic fs;
    } vec_t;

    logic clk, rst;
    logic en_s, rs_s, en_d, rs_d, en_x, rs_x;
    logic [3:0]  hc_s, vc_s;
    logic [11:0] hc_d, vc_d, hc_x, vc_x;
    logic hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s;
    logic hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d;
    logic hs_x, vs_x, hb_x, vb_x, de_x, ls_x, fs_x;

    int n_tests, n_fail, cyc;
    mdl_t m_s, m_d, m_x;
    vec_t vecs[15];

    video_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .CW(4)
    ) dut_s (
        .clk(clk), .reset(rst), .clk_en(en_s), .restart(rs_s),
        .h_count(hc_s), .v_count(vc_s), .hsync(hs_s), .vsync(vs_s),
        .hblank(hb_s), .vblank(vb_s), .de(de_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    video_timing_gen dut_d (
        .clk(clk), .reset(rst), .clk_en(en_d), .restart(rs_d),
        .h_count(hc_d), .v_count(vc_d), .hsync(hs_d), .vsync(vs_d),
        .hblank(hb_d), .vblank(vb_d), .de(de_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    video_timing_gen #(
        .H_VISIBLE(MODE_800X600_60.h.visible), .H_FRONT(MODE_800X600_60.h.front),
        .H_SYNC(MODE_800X600_60.h.sync),       .H_BACK(MODE_800X600_60.h.back),
        .V_VISIBLE(MODE_800X600_60.v.visible), .V_FRONT(MODE_800X600_60.v.front),
        .V_SYNC(MODE_800X600_60.v.sync),       .V_BACK(MODE_800X600_60.v.back),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(12)
    ) dut_x (
        .clk(clk), .reset(rst), .clk_en(en_x), .restart(rs_x),
        .h_count(hc_x), .v_count(vc_x), .hsync(hs_x), .vsync(vs_x),
        .hblank(hb_x), .vblank(vb_x), .de(de_x),
        .line_start(ls_x), .frame_start(fs_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mk_mode(input int hv, hf, hs, hb, vv, vf, vs, vb,
                                     input bit hp, vp);
        mdl_t m;
        m.hv = hv; m.hf = hf; m.hs = hs; m.hb = hb;
        m.vv = vv; m.vf = vf; m.vs = vs; m.vb = vb;
        m.hp = hp; m.vp = vp;
        m.h = 0; m.v = 0; m.ls = 1'b0; m.fs = 1'b0;
        return m;
    endfunction

    // Raster position as plain modular arithmetic over the mode totals.
    function automatic mdl_t mdl_step(input mdl_t m, input logic r, input logic en,
                                      input logic rs);
        mdl_t n = m;
        int ht = m.hv + m.hf + m.hs + m.hb;
        int vt = m.vv + m.vf + m.vs + m.vb;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (r) begin
            n.h = 0; n.v = 0;
        end else if (rs) begin
            n.h = 0; n.v = 0; n.ls = 1'b1; n.fs = 1'b1;
        end else if (en) begin
            n.h = (m.h + 1) % ht;
            if (n.h == 0) begin
                n.v  = (m.v + 1) % vt;
                n.ls = 1'b1;
                n.fs = (n.v == 0);
            end
        end
        return n;
    endfunction

    task automatic check_out(input string nm, input mdl_t m, input logic [11:0] h,
                             input logic [11:0] v, input logic hs, vs, hb, vb, de,
                             input logic ls, fs);
        logic e_hs, e_vs, e_hb, e_vb, e_de;
        int hss = m.hv + m.hf;
        int vss = m.vv + m.vf;
        e_hs = (m.h >= hss && m.h < hss + m.hs) ? m.hp : ~m.hp;
        e_vs = (m.v >= vss && m.v < vss + m.vs) ? m.vp : ~m.vp;
        e_hb = (m.h >= m.hv);
        e_vb = (m.v >= m.vv);
        e_de = ~e_hb & ~e_vb;
        n_tests++;
        if (h !== 12'(m.h) || v !== 12'(m.v) || hs !== e_hs || vs !== e_vs ||
            hb !== e_hb || vb !== e_vb || de !== e_de || ls !== m.ls || fs !== m.fs) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b",
                     nm, cyc, h, v, hs, vs, hb, vb, de, ls, fs,
                     m.h, m.v, e_hs, e_vs, e_hb, e_vb, e_de, m.ls, m.fs);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        m_s = mdl_step(m_s, rst, en_s, rs_s);
        m_d = mdl_step(m_d, rst, en_d, rs_d);
        m_x = mdl_step(m_x, rst, en_x, rs_x);
        #1;
        check_out("model_s", m_s, {8'd0, hc_s}, {8'd0, vc_s}, hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s);
        check_out("model_d", m_d, hc_d, vc_d, hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d);
        check_out("model_x", m_x, hc_x, vc_x, hs_x, vs_x, hb_x, vb_x, de_x, ls_x, fs_x);
    endtask

    initial begin
        int lo_min, lo_max, lo_cnt, last_ls_d, hi_min, hi_max, hi_cnt, last_ls_x, hmax_x;
        int de_cnt, last_fs_s;
        logic prev_hb_d;

        n_tests = 0; n_fail = 0; cyc = 0;
        m_s = mk_mode(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1);
        m_d = mk_mode(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        m_x = mk_mode(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);

        //            en    rs    h  v  hs    vs    de    ls    fs
        vecs[0]  = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; en_s = 1'b0; rs_s = 1'b0;
        en_d = 1'b1; rs_d = 1'b0; en_x = 1'b1; rs_x = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            en_s = vecs[i].en;
            rs_s = vecs[i].rs;
            tick();
            n_tests++;
            if (hc_s !== 4'(vecs[i].h) || vc_s !== 4'(vecs[i].v) || hs_s !== vecs[i].hs ||
                vs_s !== vecs[i].vs || de_s !== vecs[i].de || ls_s !== vecs[i].ls ||
                fs_s !== vecs[i].fs) begin
                n_fail++;
                $display("FAIL vec[%0d]: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                         i, hc_s, vc_s, hs_s, vs_s, de_s, ls_s, fs_s, vecs[i].h, vecs[i].v,
                         vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].ls, vecs[i].fs);
            end
        end

        // Continuous-enable run: sync windows, line periods and frame totals.
        en_s = 1'b1; rs_s = 1'b0;
        lo_min = 99999; lo_max = -1; lo_cnt = 0; last_ls_d = -1;
        hi_min = 99999; hi_max = -1; hi_cnt = 0; last_ls_x = -1; hmax_x = -1;
        de_cnt = 0; last_fs_s = -1; prev_hb_d = hb_d;
        for (int k = 0; k < 6000 && !(m_d.v == 3 && m_d.h == 300); k++) begin
            tick();
            if (hs_d === 1'b0) begin
                lo_cnt++;
                if (int'(hc_d) < lo_min) lo_min = int'(hc_d);
                if (int'(hc_d) > lo_max) lo_max = int'(hc_d);
            end
            if (hb_d === 1'b1 && prev_hb_d === 1'b0) check_int("hblank_rise_h", int'(hc_d), 640);
            prev_hb_d = hb_d;
            if (ls_d === 1'b1) begin
                if (last_ls_d >= 0) check_int("line_period_d", cyc - last_ls_d, 800);
                check_int("hsync_low_cycles_d", lo_cnt, 96);
                lo_cnt = 0; last_ls_d = cyc;
            end
            if (hs_x === 1'b1) begin
                hi_cnt++;
                if (int'(hc_x) < hi_min) hi_min = int'(hc_x);
                if (int'(hc_x) > hi_max) hi_max = int'(hc_x);
            end
            if (int'(hc_x) > hmax_x) hmax_x = int'(hc_x);
            if (ls_x === 1'b1) begin
                if (last_ls_x >= 0) check_int("line_period_x", cyc - last_ls_x, 1056);
                check_int("hsync_high_cycles_x", hi_cnt, 128);
                hi_cnt = 0; last_ls_x = cyc;
            end
            if (fs_s === 1'b1) begin
                if (last_fs_s >= 0) begin
                    check_int("frame_period_s", cyc - last_fs_s, 48);
                    check_int("de_per_frame_s", de_cnt, 12);
                end
                de_cnt = 0; last_fs_s = cyc;
            end
            if (de_s === 1'b1) de_cnt++;
        end
        check_int("reach_restart_point_d", (m_d.v == 3 && m_d.h == 300) ? 1 : 0, 1);
        check_int("hsync_low_first_d", lo_min, 656);
        check_int("hsync_low_last_d", lo_max, 751);
        check_int("hsync_high_first_x", hi_min, 840);
        check_int("hsync_high_last_x", hi_max, 967);
        check_int("h_wrap_point_x", hmax_x, 1055);

        rs_d = 1'b1;
        tick();
        check_int("restart_d_pos", int'(hc_d) * 10000 + int'(vc_d), 0);
        check_int("restart_d_pulses", {30'd0, ls_d, fs_d}, 3);
        rs_d = 1'b0;

        // One-in-four enable strobes.
        for (int k = 0; k < 400; k++) begin
            en_s = (k % 4 == 0);
            tick();
        end

        // Restart coinciding with the natural end-of-frame wrap.
        en_s = 1'b1;
        for (int k = 0; k < 200 && !(m_s.h == 7 && m_s.v == 5); k++) tick();
        check_int("reach_last_pos_s", (m_s.h == 7 && m_s.v == 5) ? 1 : 0, 1);
        rs_s = 1'b1;
        tick();
        check_int("wrap_restart_fs", {31'd0, fs_s}, 1);
        rs_s = 1'b0;
        tick();
        check_int("wrap_restart_single_fs", {30'd0, fs_s, ls_s}, 0);
        check_int("wrap_restart_next_h", int'(hc_s), 1);

        for (int k = 0; k < 3000; k++) begin
            en_s = ($urandom_range(0, 3) != 0);
            rs_s = ($urandom_range(0, 63) == 0);
            tick();
        end

        // Asynchronous reset while both syncs are active.
        en_s = 1'b1; rs_s = 1'b0;
        for (int k = 0; k < 200 && !(m_s.h == 6 && m_s.v == 4); k++) tick();
        check_int("pre_reset_syncs_s", {30'd0, hs_s, vs_s}, 1);
        #2 rst = 1'b1;
        #1;
        check_int("async_reset_pos_s", int'(hc_s) * 100 + int'(vc_s), 0);
        check_int("async_reset_flags_s", {25'd0, hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s}, 7'b1000100);
        tick();
        rst = 1'b0;
        en_s = 1'b1;
        tick();
        check_int("post_reset_first_h", int'(hc_s), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator producing horizontal and vertical position, sync, blanking and data-enable for any progressive video mode. It replaces the single-axis horizontal counter with a combined H/V engine. It runs on the system clock with a pixel-rate `clk_en` strobe and feeds the pixel/matrix renderer and the VGA output stage. Defaults give 640x480@60 timing; other modes are selected by parameter only.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync
- CW, 12, counter width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  pixel strobe; counters advance only when high
- restart  in  1  synchronous request to jump to position (0,0)
- h_count  out  CW  current pixel column, 0..H_TOTAL-1
- v_count  out  CW  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at H_SYNC_POL level when active
- vsync  out  1  vertical sync at V_SYNC_POL level when active
- hblank  out  1  high when h_count >= H_VISIBLE
- vblank  out  1  high when v_count >= V_VISIBLE
- de  out  1  data enable = ~hblank & ~vblank
- line_start  out  1  one-clk pulse on entry to h_count = 0
- frame_start  out  1  one-clk pulse on entry to (0,0)

## Operation
- Derived constants: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Horizontal: on clk_en, h_count increments; at H_TOTAL-1 it wraps to 0. Exactly H_TOTAL positions per line.
- Vertical: v_count increments only on the clk_en cycle where h_count wraps; at V_TOTAL-1 it wraps to 0 simultaneously with h_count.
- hsync is active for H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC.
- vsync is active for V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC. It changes only at line boundaries.
- restart: on any clk edge with restart=1, counters load (0,0) regardless of clk_en. frame_start and line_start pulse on the following cycle.
- restart coinciding with a natural wrap produces one pulse of each, not two.
- Reset values: h_count=0, v_count=0, hblank=0, vblank=0, de=1, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, line_start=0, frame_start=0.
- While clk_en=0 all outputs hold their values, except line_start and frame_start, which are forced to 0.
- Asynchronous reset mid-frame returns all outputs to reset values immediately. Counting resumes from (0,0) on the first clk_en after release.

## Timing
- All outputs are registered, decoded from next-state counter values. hsync, vsync, hblank, vblank and de therefore correspond to the h_count/v_count presented in the same cycle: zero skew, no pipeline offset between position and flags.
- Position-to-output latency: a counter change on clk edge N is visible with matching flags after edge N.
- line_start and frame_start are high for exactly one clk cycle, coincident with the cycle in which h_count reads 0 (and v_count reads 0 for frame_start).
- clk_en may be any duty cycle, including constantly high; no back-to-back restrictions.
- restart takes precedence over clk_en and over wrap; reset takes precedence over everything.

## Structure
- Shared package `video_timing_pkg`:
  - mode constants for 640x480@60, 800x600@60 and 1024x768@60
  - a helper function returning total = visible+front+sync+back
- Sub-module `axis_counter` (one instance per axis):
  - parameters VISIBLE, FRONT, SYNC, BACK, POL, CW
  - inputs `advance` and `restart`
  - outputs: count, sync, blank, and a `wrap` strobe
- The horizontal instance's `wrap` drives the vertical instance's `advance`.
- The top level registers de, line_start and frame_start.

## Test plan
- Reset with clk_en=1 continuous, defaults: hsync low exactly for h_count 656..751; hblank rises at h_count=640; line_start period = 800 clk.
- Run one full frame: vsync low exactly for v_count 490..491; frame_start period = 420000 clk; de high for exactly 307200 cycles per frame.
- clk_en high one cycle in four: counters and syncs advance only on strobes; line_start and frame_start each remain single-clk pulses.
- Assert restart at (h=300, v=200): next cycle shows (0,0) with frame_start=1 and line_start=1. Restart at (799,524) yields a single frame_start.
- Assert async reset at (h=700, v=495): outputs immediately return to reset values, including vsync=1 (inactive); release, then first clk_en gives h_count=1.
- Parameter sweep with 800x600@60 and H_SYNC_POL=1: hsync high for h_count 840..967; H_TOTAL=1056 and V_TOTAL=628 checked by wrap points.
